// File: rtl/branch_resolve_ctrl_if.sv
// ============================================================================
// Module      : branch_resolve_ctrl_if
// Description : EX-resolution, redirect and predictor-update bundle for
//               branch_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_is_ctrl;
    logic [31:0]      ex_pc;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_next_pc;
    logic             ex_actual_taken;
    logic [31:0]      ex_actual_next_pc;
    logic             upd_ready;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             upd_valid;
    logic [31:0]      pc_for_update;
    logic [31:0]      update_next_pc;
    logic             update_taken;
    logic             fifo_full;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] drop_cnt;

    // Pipeline / predictor side
    modport master (
        output ex_valid, ex_is_ctrl, ex_pc, ex_pred_taken, ex_pred_next_pc,
               ex_actual_taken, ex_actual_next_pc, upd_ready,
        input  flush, redirect_pc, upd_valid, pc_for_update, update_next_pc,
               update_taken, fifo_full, mispredict_cnt, branch_cnt, drop_cnt
    );

    // Controller side
    modport slave (
        input  ex_valid, ex_is_ctrl, ex_pc, ex_pred_taken, ex_pred_next_pc,
               ex_actual_taken, ex_actual_next_pc, upd_ready,
        output flush, redirect_pc, upd_valid, pc_for_update, update_next_pc,
               update_taken, fifo_full, mispredict_cnt, branch_cnt, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : EX-stage branch resolution, one-cycle flush/redirect with a
//               wrong-path shadow window, and a predictor training queue.
//               Optional perf counters: `define BRANCH_RESOLVE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_ctrl_if.slave bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_SH_W  = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

    localparam logic [c_PTR_W:0]  c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_SH_W-1:0] c_SH_LOAD  = c_SH_W'(SHADOW_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH  = 2'd1;
    localparam logic [1:0] c_ST_SHADOW = 2'd2;

    logic [1:0]          r_state;
    logic [c_SH_W-1:0]   r_shadow_cnt;
    logic [31:0]         r_redirect_pc;

    logic [31:0]         r_mem_pc  [FIFO_DEPTH];
    logic [31:0]         r_mem_npc [FIFO_DEPTH];
    logic                r_mem_tk  [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;

    logic w_res;
    logic w_mis;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_res = bus.ex_valid & bus.ex_is_ctrl & (r_state == c_ST_IDLE);
    assign w_mis = w_res & ((bus.ex_pred_taken != bus.ex_actual_taken) |
                            (bus.ex_actual_taken &
                             (bus.ex_pred_next_pc != bus.ex_actual_next_pc)));

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_pop   = ~w_empty & bus.upd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push  = w_res & (~w_full | w_pop);

    // ------------------------------------------------------------------
    // Recovery sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_shadow_cnt  <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mis) begin
                        r_redirect_pc <= bus.ex_actual_next_pc;
                        r_state       <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    r_shadow_cnt <= c_SH_LOAD;
                    r_state      <= (SHADOW_CYCLES == 0) ? c_ST_IDLE : c_ST_SHADOW;
                end
                c_ST_SHADOW: begin
                    r_shadow_cnt <= r_shadow_cnt - 1'b1;
                    if (r_shadow_cnt <= c_SH_W'(1)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.flush       = (r_state == c_ST_FLUSH);
    assign bus.redirect_pc = r_redirect_pc;

    // ------------------------------------------------------------------
    // Training queue; storage is cleared so the head never shows X.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_pc[i]  <= '0;
                r_mem_npc[i] <= '0;
                r_mem_tk[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]  <= bus.ex_pc;
                r_mem_npc[r_wr_ptr] <= bus.ex_actual_next_pc;
                r_mem_tk[r_wr_ptr]  <= bus.ex_actual_taken;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.upd_valid      = ~w_empty;
    assign bus.pc_for_update  = r_mem_pc[r_rd_ptr];
    assign bus.update_next_pc = r_mem_npc[r_rd_ptr];
    assign bus.update_taken   = r_mem_tk[r_rd_ptr];
    assign bus.fifo_full      = w_full;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    logic             w_drop;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_drop = w_res & ~w_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis_cnt  <= '0;
            r_br_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_mis) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
            end
            if (w_res) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.mispredict_cnt = r_mis_cnt;
    assign bus.branch_cnt     = r_br_cnt;
    assign bus.drop_cnt       = r_drop_cnt;
`else
    assign bus.mispredict_cnt = '0;
    assign bus.branch_cnt     = '0;
    assign bus.drop_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Directed + random bench for branch_resolve_ctrl with a
//               queue-based reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_ctrl;

    localparam int DEPTH = 4;
    localparam int SH    = 2;
    localparam int CW    = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.CNT_W(CW)) bus();

    branch_resolve_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .SHADOW_CYCLES(SH),
        .CNT_W        (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
    } rec_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    rec_t        q[$];
    int          blank;
    logic        m_flush;
    logic [31:0] m_redir;
    logic [31:0] m_mis;
    logic [31:0] m_br;
    logic [31:0] m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("redirect_pc", bus.redirect_pc, m_redir);
        chk("upd_valid", 32'(bus.upd_valid), 32'(q.size() != 0));
        chk("fifo_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
        if (q.size() != 0) begin
            chk("head_pc", bus.pc_for_update, q[0].pc);
            chk("head_npc", bus.update_next_pc, q[0].npc);
            chk("head_taken", 32'(bus.update_taken), 32'(q[0].tk));
        end
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("mispredict_cnt", bus.mispredict_cnt, m_mis);
        chk("branch_cnt", bus.branch_cnt, m_br);
        chk("drop_cnt", bus.drop_cnt, m_drop);
`else
        chk("mispredict_cnt", bus.mispredict_cnt, 32'd0);
        chk("branch_cnt", bus.branch_cnt, 32'd0);
        chk("drop_cnt", bus.drop_cnt, 32'd0);
`endif
    endtask

    // Advance one clock: the model consumes the inputs currently driven,
    // then the DUT outputs are compared just after the edge.
    task automatic tick();
        logic res;
        logic mis;
        logic pop;
        rec_t r;
        if (reset) begin
            q.delete();
            blank   = 0;
            m_flush = 1'b0;
            m_redir = '0;
            m_mis   = '0;
            m_br    = '0;
            m_drop  = '0;
        end else begin
            res = bus.ex_valid && bus.ex_is_ctrl && (blank == 0);
            mis = res && ((bus.ex_pred_taken != bus.ex_actual_taken) ||
                          (bus.ex_actual_taken && (bus.ex_pred_next_pc != bus.ex_actual_next_pc)));
            pop = (q.size() != 0) && bus.upd_ready;
            m_flush = mis;
            if (blank > 0) blank--;
            if (mis) begin
                blank   = 1 + SH;
                m_redir = bus.ex_actual_next_pc;
                m_mis++;
            end
            if (res) m_br++;
            if (pop) void'(q.pop_front());
            if (res) begin
                if (q.size() < DEPTH) begin
                    r.pc  = bus.ex_pc;
                    r.npc = bus.ex_actual_next_pc;
                    r.tk  = bus.ex_actual_taken;
                    q.push_back(r);
                end else begin
                    m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic br(input logic [31:0] pc, input logic pt, input logic [31:0] pnpc,
                      input logic at, input logic [31:0] anpc, input logic rdy);
        bus.ex_valid          = 1'b1;
        bus.ex_is_ctrl        = 1'b1;
        bus.ex_pc             = pc;
        bus.ex_pred_taken     = pt;
        bus.ex_pred_next_pc   = pnpc;
        bus.ex_actual_taken   = at;
        bus.ex_actual_next_pc = anpc;
        bus.upd_ready         = rdy;
        tick();
    endtask

    task automatic idle(input logic rdy);
        bus.ex_valid   = 1'b0;
        bus.ex_is_ctrl = 1'b0;
        bus.upd_ready  = rdy;
        tick();
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] tgt;
        reset                 = 1'b1;
        bus.ex_valid          = 1'b0;
        bus.ex_is_ctrl        = 1'b0;
        bus.ex_pc             = '0;
        bus.ex_pred_taken     = 1'b0;
        bus.ex_pred_next_pc   = '0;
        bus.ex_actual_taken   = 1'b0;
        bus.ex_actual_next_pc = '0;
        bus.upd_ready         = 1'b0;
        idle(0);
        idle(0);
        chk("rst_head_pc", bus.pc_for_update, 32'd0);
        chk("rst_head_npc", bus.update_next_pc, 32'd0);
        chk("rst_head_taken", 32'(bus.update_taken), 32'd0);
        reset = 1'b0;

        // Correct not-taken branch
        br(32'h10, 0, 32'h14, 0, 32'h14, 1);
        chk("t1_flush", 32'(bus.flush), 32'd0);
        chk("t1_pc", bus.pc_for_update, 32'h10);
        chk("t1_npc", bus.update_next_pc, 32'h14);
        idle(1);
        chk("t1_popped", 32'(bus.upd_valid), 32'd0);

        // Mispredict, then wrong-path mispredicts through flush and shadow
        br(32'h20, 0, 32'h24, 1, 32'h40, 1);
        chk("t2_flush", 32'(bus.flush), 32'd1);
        chk("t2_redirect", bus.redirect_pc, 32'h40);
        for (int i = 0; i < 4; i++) begin
            br(32'h80 + 32'(i * 4), 0, 32'h84 + 32'(i * 4), 1, 32'h300 + 32'(i * 4), 1);
        end
        chk("t2_third_flush", 32'(bus.flush), 32'd1);
        chk("t2_third_redirect", bus.redirect_pc, 32'h30c);
        repeat (5) idle(1);
        chk("t2_redirect_hold", bus.redirect_pc, 32'h30c);

        // JALR target mismatch
        br(32'h50, 1, 32'h100, 1, 32'h200, 1);
        chk("t3_flush", 32'(bus.flush), 32'd1);
        chk("t3_redirect", bus.redirect_pc, 32'h200);
        repeat (5) idle(1);

        // Overflow with predictor stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            br(32'h400 + 32'(i * 4), 0, 32'h404 + 32'(i * 4), 0, 32'h404 + 32'(i * 4), 0);
        end
        chk("t4_full", 32'(bus.fifo_full), 32'd1);
        chk("t4_head", bus.pc_for_update, 32'h400);
        repeat (5) idle(1);
        chk("t4_drained", 32'(bus.upd_valid), 32'd0);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            br(32'h500 + 32'(i * 4), 0, 32'h504 + 32'(i * 4), 0, 32'h504 + 32'(i * 4), 0);
        end
        br(32'h600, 1, 32'h700, 1, 32'h700, 1);
        chk("t5_full", 32'(bus.fifo_full), 32'd1);
        chk("t5_head", bus.pc_for_update, 32'h504);
        repeat (5) idle(1);

        // Reset during shadow with three queued entries
        br(32'h800, 0, 32'h804, 0, 32'h804, 0);
        br(32'h804, 0, 32'h808, 0, 32'h808, 0);
        br(32'h808, 0, 32'h80c, 1, 32'h900, 0);
        idle(0);
        idle(0);
        reset = 1'b1;
        idle(0);
        reset = 1'b0;
        chk("t6_flush", 32'(bus.flush), 32'd0);
        chk("t6_upd_valid", 32'(bus.upd_valid), 32'd0);
        br(32'ha00, 0, 32'ha04, 0, 32'ha04, 0);
        chk("t6_accept", 32'(bus.upd_valid), 32'd1);
        chk("t6_pc", bus.pc_for_update, 32'ha00);
        idle(1);

        // Randomized traffic
        repeat (400) begin
            reset = ($urandom_range(0, 99) == 0);
            pc  = $urandom & 32'hffff_fffc;
            tgt = $urandom & 32'hffff_fffc;
            bus.ex_valid          = ($urandom_range(0, 3) != 0);
            bus.ex_is_ctrl        = ($urandom_range(0, 4) < 3);
            bus.ex_pc             = pc;
            bus.ex_actual_taken   = $urandom_range(0, 1);
            bus.ex_actual_next_pc = bus.ex_actual_taken ? tgt : pc + 32'd4;
            if ($urandom_range(0, 9) < 7) begin
                bus.ex_pred_taken   = bus.ex_actual_taken;
                bus.ex_pred_next_pc = bus.ex_actual_next_pc;
            end else begin
                bus.ex_pred_taken   = $urandom_range(0, 1);
                bus.ex_pred_next_pc = ($urandom_range(0, 1) == 1) ? bus.ex_actual_next_pc
                                                                  : ($urandom & 32'hffff_fffc);
            end
            bus.upd_ready = $urandom_range(0, 1);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
